// File: rtl/sram_ctrl.sv
// Sequences CS/OE/WE strobes for an asynchronous SRAM from a CPU req/ready handshake.
// Latency: done in cycle 3+WAIT_STATES after acceptance, ready again in cycle 4+WAIT_STATES+TURNAROUND.
// Backpressure: ready=0 for the whole access; req seen while busy is dropped, never queued.
module sram_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int WAIT_STATES = 1,
   parameter int TURNAROUND  = 1
) (
   input  logic                  clk,
   input  logic                  reset_bar,
   input  logic                  req,
   input  logic                  wr,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ready,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_dout,
   input  logic [DATA_WIDTH-1:0] sram_din,
   output logic                  sram_drive,
   output logic                  sram_cs_bar,
   output logic                  sram_oe_bar,
   output logic                  sram_we_bar
);

   // Wait-state and turnaround counts fit in 4 bits (0..15).
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LP_WAIT    = CNT_W'(WAIT_STATES);
   localparam logic [CNT_W-1:0] LP_TURN_M1 = CNT_W'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);
   localparam bit               LP_HAS_TURN = (TURNAROUND > 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_HOLD   = 3'd3,
      S_TURN   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_nxt_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_nxt_cnt;
   logic                  r_wr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  r_ready;
   logic                  r_done;
   logic                  r_drive;
   logic                  r_cs_bar;
   logic                  r_oe_bar;
   logic                  r_we_bar;

   logic                  w_accept;
   logic                  w_op_wr;
   logic                  w_last_strobe;

   logic                  w_ready;
   logic                  w_done;
   logic                  w_drive;
   logic                  w_cs_bar;
   logic                  w_oe_bar;
   logic                  w_we_bar;

   // A request is only taken while idle; anything else on req is ignored.
   assign w_accept      = (r_state == S_IDLE) && req;
   // Direction of the access the next state belongs to: fresh wr when accepting, latched otherwise.
   assign w_op_wr       = w_accept ? wr : r_wr;
   assign w_last_strobe = (r_state == S_STROBE) && (r_cnt == '0);

   // State and down-counter register.
   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
      end
   end

   // Next-state logic; the counter is loaded on entry to STROBE/TURN and counts down to zero.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_nxt_state = S_SETUP;
            end
         end
         S_SETUP: begin
            w_nxt_state = S_STROBE;
            w_nxt_cnt   = LP_WAIT;
         end
         S_STROBE: begin
            if (r_cnt == '0) begin
               w_nxt_state = S_HOLD;
            end else begin
               w_nxt_cnt = r_cnt - 4'd1;
            end
         end
         S_HOLD: begin
            if (LP_HAS_TURN) begin
               w_nxt_state = S_TURN;
               w_nxt_cnt   = LP_TURN_M1;
            end else begin
               w_nxt_state = S_IDLE;
            end
         end
         S_TURN: begin
            if (r_cnt == '0) begin
               w_nxt_state = S_IDLE;
            end else begin
               w_nxt_cnt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
         end
      endcase
   end

   // Output decode from the next state so every strobe comes straight out of a flop.
   always_comb begin
      w_ready  = 1'b0;
      w_done   = 1'b0;
      w_drive  = 1'b0;
      w_cs_bar = 1'b1;
      w_oe_bar = 1'b1;
      w_we_bar = 1'b1;
      case (w_nxt_state)
         S_IDLE: begin
            w_ready = 1'b1;
         end
         S_SETUP: begin
            w_cs_bar = 1'b0;
            w_oe_bar = w_op_wr;
            w_drive  = w_op_wr;
         end
         S_STROBE: begin
            w_cs_bar = 1'b0;
            w_oe_bar = w_op_wr;
            w_we_bar = !w_op_wr;
            w_drive  = w_op_wr;
         end
         S_HOLD: begin
            // WE has already risen; keep driving so data hold time is met.
            w_cs_bar = 1'b0;
            w_drive  = w_op_wr;
            w_done   = 1'b1;
         end
         S_TURN: begin
            w_ready = 1'b0;
         end
         default: begin
            w_ready = 1'b0;
         end
      endcase
   end

   // Registered strobes and handshake outputs; reset forces the bus quiet immediately.
   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_drive  <= 1'b0;
         r_cs_bar <= 1'b1;
         r_oe_bar <= 1'b1;
         r_we_bar <= 1'b1;
      end else begin
         r_ready  <= w_ready;
         r_done   <= w_done;
         r_drive  <= w_drive;
         r_cs_bar <= w_cs_bar;
         r_oe_bar <= w_oe_bar;
         r_we_bar <= w_we_bar;
      end
   end

   // Request capture; address and write data stay put until the next accepted request.
   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_wr    <= wr;
         r_addr  <= addr;
         r_wdata <= wdata;
      end
   end

   // Read data sampled at the end of the final strobe cycle, while OE is still low.
   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         r_rdata <= '0;
      end else if (w_last_strobe && !r_wr) begin
         r_rdata <= sram_din;
      end
   end

   assign ready       = r_ready;
   assign done        = r_done;
   assign rdata       = r_rdata;
   assign sram_addr   = r_addr;
   assign sram_dout   = r_wdata;
   assign sram_drive  = r_drive;
   assign sram_cs_bar = r_cs_bar;
   assign sram_oe_bar = r_oe_bar;
   assign sram_we_bar = r_we_bar;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl across four parameter sets with a behavioural SRAM per instance.
// Instance 0: 8/16 W1 T1, 1: W0 T0, 2: W3 T0, 3: 16/20 W1 T1.
// Per-access history vectors hold one bit per cycle after acceptance (bit i = cycle i).
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        wr;
   logic [19:0] addr;
   logic [15:0] wdata;
   int          sel;

   logic [3:0]  ready_v, done_v, drive_v, cs_v, oe_v, we_v;
   logic [15:0] rdata_v [4];
   logic [19:0] saddr_v [4];

   int n_chk  = 0;
   int n_fail = 0;
   int n_viol = 0;

   logic [15:0] h_done, h_rdy, h_cs, h_oe, h_we, h_drv, h_addr;
   logic [15:0] h_rd;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      localparam int DW = (k == 3) ? 16 : 8;
      localparam int AW = (k == 3) ? 20 : 16;
      localparam int WS = (k == 2) ? 3 : ((k == 1) ? 0 : 1);
      localparam int TA = (k == 1 || k == 2) ? 0 : 1;

      logic [DW-1:0] rd, dout, din;
      logic [AW-1:0] sa;
      logic [DW-1:0] mem [256];

      sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS), .TURNAROUND(TA)) u_dut (
         .clk         (clk),
         .reset_bar   (rst_n),
         .req         (req && (sel == k)),
         .wr          (wr),
         .addr        (addr[AW-1:0]),
         .wdata       (wdata[DW-1:0]),
         .ready       (ready_v[k]),
         .done        (done_v[k]),
         .rdata       (rd),
         .sram_addr   (sa),
         .sram_dout   (dout),
         .sram_din    (din),
         .sram_drive  (drive_v[k]),
         .sram_cs_bar (cs_v[k]),
         .sram_oe_bar (oe_v[k]),
         .sram_we_bar (we_v[k])
      );

      assign din        = (!cs_v[k] && !oe_v[k]) ? mem[sa[7:0]] : '0;
      assign rdata_v[k] = 16'(rd);
      assign saddr_v[k] = 20'(sa);

      always @(posedge clk) begin
         if (!cs_v[k] && !we_v[k]) mem[sa[7:0]] <= dout;
      end
   end

   // Bus-contention / strobe-legality monitor over all instances.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if ((!oe_v[k] && drive_v[k]) || (!we_v[k] && (cs_v[k] || !drive_v[k])))
            n_viol++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one access on instance k at the current negedge (cycle 0), record n cycles.
   // poke pulses req with addr FFFFF while the access is in flight.
   task automatic access(input int k, input bit w, input logic [19:0] a,
                         input logic [15:0] d, input int n, input bit poke);
      sel = k; req = 1'b1; wr = w; addr = a; wdata = d;
      h_done = '0; h_rdy = '0; h_cs = '0; h_oe = '0; h_we = '0; h_drv = '0; h_addr = '0;
      h_rd = '0;
      @(posedge clk); #1;
      req = 1'b0; wr = ~w; addr = 20'h0AAAA; wdata = ~d;
      for (int i = 1; i <= n; i++) begin
         if (poke && i == 2) begin req = 1'b1; addr = 20'hFFFFF; end
         if (poke && i == 3) req = 1'b0;
         @(negedge clk);
         h_done[i] = done_v[k];
         h_rdy[i]  = ready_v[k];
         h_cs[i]   = ~cs_v[k];
         h_oe[i]   = ~oe_v[k];
         h_we[i]   = ~we_v[k];
         h_drv[i]  = drive_v[k];
         h_addr[i] = (saddr_v[k] == a);
         if (done_v[k]) h_rd = rdata_v[k];
      end
   endtask

   initial begin
      int dcount;
      rst_n = 1'b0; req = 1'b1; sel = 0; wr = 1'b1; addr = 20'h00001; wdata = 16'h00FF;

      // Reset held two cycles with req asserted.
      @(negedge clk); @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("rst_ready", ready_v[k], 1);
         check("rst_done",  done_v[k],  0);
         check("rst_rdata", rdata_v[k], 0);
         check("rst_strb",  {cs_v[k], oe_v[k], we_v[k], drive_v[k]}, 4'b1110);
      end
      req = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", {ready_v[0], cs_v[0]}, 2'b11);

      // Instance 0: W=1, T=1.
      access(0, 1'b1, 20'h01234, 16'h00A5, 6, 1'b0);
      check("w0_we",    h_we,   16'h000C);
      check("w0_done",  h_done, 16'h0010);
      check("w0_ready", h_rdy,  16'h0040);
      check("w0_cs",    h_cs,   16'h001E);
      check("w0_drive", h_drv,  16'h001E);
      check("w0_oe",    h_oe,   16'h0000);

      access(0, 1'b0, 20'h01234, 16'h0000, 6, 1'b0);
      check("r0_oe",    h_oe,   16'h000E);
      check("r0_done",  h_done, 16'h0010);
      check("r0_drive", h_drv,  16'h0000);
      check("r0_rdata", h_rd,   16'h00A5);

      access(0, 1'b1, 20'h01234, 16'h005A, 6, 1'b0);
      check("w0_keeps_rdata", rdata_v[0], 16'h00A5);

      access(0, 1'b0, 20'h01234, 16'h0000, 8, 1'b1);
      check("poke_done",  h_done, 16'h0010);
      check("poke_cs",    h_cs,   16'h001E);
      check("poke_ready", h_rdy,  16'h01C0);
      check("poke_addr",  h_addr, 16'h01FE);
      check("poke_rdata", h_rd,   16'h005A);

      // Instance 1: W=0, T=0, back-to-back period 4.
      access(1, 1'b1, 20'h00012, 16'h003C, 4, 1'b0);
      check("w1_we",    h_we,   16'h0004);
      check("w1_done",  h_done, 16'h0008);
      check("w1_ready", h_rdy,  16'h0010);
      access(1, 1'b0, 20'h00012, 16'h0000, 4, 1'b0);
      check("r1_oe",    h_oe,   16'h0006);
      check("r1_done",  h_done, 16'h0008);
      check("r1_rdata", h_rd,   16'h003C);
      access(1, 1'b0, 20'h00012, 16'h0000, 4, 1'b0);
      check("r1b_done", h_done, 16'h0008);
      check("r1b_ready", h_rdy, 16'h0010);

      // Instance 2: W=3, T=0, back-to-back period 7.
      access(2, 1'b1, 20'h00034, 16'h00C3, 7, 1'b0);
      check("w2_we",    h_we,   16'h003C);
      check("w2_done",  h_done, 16'h0040);
      access(2, 1'b0, 20'h00034, 16'h0000, 7, 1'b0);
      check("r2_oe",    h_oe,   16'h003E);
      check("r2_done",  h_done, 16'h0040);
      check("r2_ready", h_rdy,  16'h0080);
      check("r2_rdata", h_rd,   16'h00C3);

      // Reset during the write strobe on instance 0.
      sel = 0; req = 1'b1; wr = 1'b1; addr = 20'h00055; wdata = 16'h0077;
      @(posedge clk); #1; req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mw_in_strobe", we_v[0], 0);
      rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      check("mw_abort", {we_v[0], cs_v[0], drive_v[0], done_v[0], ready_v[0]}, 5'b11001);
      dcount = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done_v[0]) dcount++;
      end
      check("mw_no_done", dcount, 0);
      check("mw_idle",    ready_v[0], 1);

      // Instance 3: 16-bit data, 20-bit address.
      access(3, 1'b1, 20'hFFFFF, 16'hBEEF, 6, 1'b0);
      check("w3_done",  h_done, 16'h0010);
      access(3, 1'b0, 20'hFFFFF, 16'h0000, 6, 1'b0);
      check("r3_rdata", h_rd,   16'hBEEF);
      check("r3_addr",  saddr_v[3], 20'hFFFFF);

      check("contention", n_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
